// File: rtl/cpu_mem_responder.sv
// CPU bus memory responder: word RAM, 16-word I/O window (LEDs/switches/timer/status), unmapped hole.
// Read data registered with 1-cycle latency, updated every cycle; no backpressure (no stall/ready).
module cpu_mem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] IO_BASE   = 16'hFFF0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Mem_Addr,
  input  logic        Mem_Write,
  input  logic [15:0] Data_In,
  output logic [15:0] Mem_Data,
  input  logic [7:0]  Switches,
  output logic [7:0]  LEDs,
  output logic        Bus_Error
);

  localparam int RAM_WORDS = 1 << ADDR_BITS;

  localparam logic [3:0] OFF_LEDS   = 4'h0;
  localparam logic [3:0] OFF_SWITCH = 4'h1;
  localparam logic [3:0] OFF_TIMER  = 4'h2;
  localparam logic [3:0] OFF_STATUS = 4'h3;

  logic [15:0] ram_q [RAM_WORDS];

  logic [15:0] mem_data_q, mem_data_d;
  logic [7:0]  leds_q, leds_d;
  logic        berr_q, berr_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  sw_sync_q, sw_sync_d;

  logic                 is_ram;
  logic                 is_io;
  logic [ADDR_BITS-1:0] ram_idx;
  logic [3:0]           io_off;
  logic [15:0]          rd_dat;

  assign is_ram  = (Mem_Addr >> ADDR_BITS) == 16'd0;
  assign is_io   = Mem_Addr >= IO_BASE;
  assign ram_idx = Mem_Addr[ADDR_BITS-1:0];
  // IO_BASE is 16-word aligned, so the low nibble is the register offset.
  assign io_off  = Mem_Addr[3:0];

  // RAM contents survive reset; writes during a reset cycle are dropped.
  always_ff @(posedge Clock) begin
    if (Reset && Mem_Write && is_ram) begin
      ram_q[ram_idx] <= Data_In;
    end
  end

  always_comb begin
    rd_dat    = 16'h0000;
    leds_d    = leds_q;
    berr_d    = berr_q;
    timer_d   = timer_q + 16'd1;
    sw_sync_d = Switches;

    if (is_ram) begin
      rd_dat = ram_q[ram_idx];
    end else if (is_io) begin
      case (io_off)
        OFF_LEDS:   rd_dat = {8'h00, leds_q};
        OFF_SWITCH: rd_dat = {8'h00, sw_sync_q};
        OFF_TIMER:  rd_dat = timer_q;
        OFF_STATUS: rd_dat = {15'b0, berr_q};
        default:    rd_dat = 16'h0000;
      endcase
    end

    if (Mem_Write && is_io) begin
      case (io_off)
        OFF_LEDS:   leds_d  = Data_In[7:0];
        OFF_TIMER:  timer_d = 16'h0000;
        OFF_STATUS: if (Data_In[0]) berr_d = 1'b0;
        default:    ;
      endcase
    end

    if (!is_ram && !is_io) begin
      berr_d = 1'b1;
    end

    mem_data_d = Mem_Write ? Data_In : rd_dat;
  end

  // Mem_Data acts as the second stage of the switch synchronizer.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      mem_data_q <= 16'h0000;
      leds_q     <= 8'h00;
      berr_q     <= 1'b0;
      timer_q    <= 16'h0000;
      sw_sync_q  <= 8'h00;
    end else begin
      mem_data_q <= mem_data_d;
      leds_q     <= leds_d;
      berr_q     <= berr_d;
      timer_q    <= timer_d;
      sw_sync_q  <= sw_sync_d;
    end
  end

  assign Mem_Data  = mem_data_q;
  assign LEDs      = leds_q;
  assign Bus_Error = berr_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed scenarios then random bus traffic,
// checked against a behavioural model of the memory map.
module tb_cpu_mem_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Mem_Addr;
  logic        Mem_Write;
  logic [15:0] Data_In;
  logic [15:0] Mem_Data;
  logic [7:0]  Switches;
  logic [7:0]  LEDs;
  logic        Bus_Error;

  always #5 Clock = ~Clock;

  cpu_mem_responder #(.ADDR_BITS(10), .IO_BASE(16'hFFF0)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Mem_Addr  (Mem_Addr),
    .Mem_Write (Mem_Write),
    .Data_In   (Data_In),
    .Mem_Data  (Mem_Data),
    .Switches  (Switches),
    .LEDs      (LEDs),
    .Bus_Error (Bus_Error)
  );

  int tests = 0;
  int fails = 0;

  // Model state: RAM image, LED value, error flag, cycles since timer clear,
  // switch value a read would see at the next edge.
  logic [15:0] m_ram [1024];
  logic [7:0]  m_leds;
  bit          m_berr;
  int unsigned m_tcnt;
  logic [7:0]  m_sw;
  logic [15:0] exp_md;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    logic [15:0] off;
    if (a < 16'd1024) return m_ram[a[9:0]];
    if (a >= 16'hFFF0) begin
      off = a - 16'hFFF0;
      case (off)
        16'd0:   return {8'h00, m_leds};
        16'd1:   return {8'h00, m_sw};
        16'd2:   return 16'(m_tcnt);
        16'd3:   return {15'b0, m_berr};
        default: return 16'h0000;
      endcase
    end
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [15:0] a, input bit w, input logic [15:0] d,
                      input bit r, input bit ck, input string tag);
    logic [15:0] rd;
    logic [7:0]  sw_now;
    @(negedge Clock);
    Mem_Addr = a; Mem_Write = w; Data_In = d; Reset = r;
    rd     = model_read(a);
    sw_now = Switches;
    @(posedge Clock);
    #1;
    if (!r) begin
      exp_md = 16'h0000;
      m_leds = 8'h00; m_berr = 1'b0; m_tcnt = 0; m_sw = 8'h00;
    end else begin
      exp_md = w ? d : rd;
      if (w && a < 16'd1024) m_ram[a[9:0]] = d;
      if (w && a == 16'hFFF0) m_leds = d[7:0];
      if (w && a == 16'hFFF2) m_tcnt = 0;
      else m_tcnt++;
      if (a >= 16'd1024 && a < 16'hFFF0) m_berr = 1'b1;
      else if (w && a == 16'hFFF3 && d[0]) m_berr = 1'b0;
      m_sw = sw_now;
    end
    if (ck) begin
      check({tag, ".mem_data"}, Mem_Data, exp_md);
      check({tag, ".leds"}, {8'h00, LEDs}, {8'h00, m_leds});
      check({tag, ".bus_error"}, {15'b0, Bus_Error}, {15'b0, m_berr});
    end
  endtask

  initial begin
    logic [15:0] a, d;
    bit          w;
    int          kind;

    Reset = 1'b0; Mem_Addr = 16'h0000; Mem_Write = 1'b0;
    Data_In = 16'h0000; Switches = 8'h00;
    m_leds = 8'h00; m_berr = 1'b0; m_tcnt = 0; m_sw = 8'h00;

    // 1: reset then timer read straight after
    step(16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b1, "rst0");
    step(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, "rst1");
    check("rst.mem_data", Mem_Data, 16'h0000);
    check("rst.leds", {8'h00, LEDs}, 16'h0000);
    check("rst.bus_error", {15'b0, Bus_Error}, 16'h0000);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b1, 1'b1, "timer_after_rst");
    check("timer_after_rst.const", Mem_Data, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      step(16'(i), 1'b1, 16'($urandom), 1'b1, 1'b1, "preload_lo");
      step(16'(1008 + i), 1'b1, 16'($urandom), 1'b1, 1'b1, "preload_hi");
    end

    // 2: RAM write/read, write discarded under reset
    step(16'h0005, 1'b1, 16'hBEEF, 1'b1, 1'b1, "ram_wr");
    check("ram_wr.echo", Mem_Data, 16'hBEEF);
    step(16'h0005, 1'b0, 16'h0000, 1'b1, 1'b1, "ram_rd");
    check("ram_rd.const", Mem_Data, 16'hBEEF);
    d = m_ram[6];
    step(16'h0006, 1'b1, 16'h1111, 1'b0, 1'b1, "ram_wr_in_rst");
    step(16'h0006, 1'b0, 16'h0000, 1'b1, 1'b1, "ram_rd_after_rst");
    check("ram_rd_after_rst.prior", Mem_Data, d);

    // 3: LEDs and switch synchronizer
    step(16'hFFF0, 1'b1, 16'h12A5, 1'b1, 1'b1, "led_wr");
    check("led_wr.const", {8'h00, LEDs}, 16'h00A5);
    step(16'hFFF0, 1'b0, 16'h0000, 1'b1, 1'b1, "led_rd");
    check("led_rd.const", Mem_Data, 16'h00A5);
    step(16'hFFF1, 1'b1, 16'h00FF, 1'b1, 1'b1, "sw_wr_ignored");
    Switches = 8'h3C;
    step(16'hFFF1, 1'b0, 16'h0000, 1'b1, 1'b1, "sw_edge1");
    check("sw_edge1.const", Mem_Data, 16'h0000);
    step(16'hFFF1, 1'b0, 16'h0000, 1'b1, 1'b1, "sw_edge2");
    check("sw_edge2.const", Mem_Data, 16'h003C);
    step(16'hFFF1, 1'b0, 16'h0000, 1'b1, 1'b1, "sw_edge3");
    check("sw_edge3.const", Mem_Data, 16'h003C);

    // 4: timer clear and wrap
    step(16'hFFF2, 1'b1, 16'h5555, 1'b1, 1'b1, "tmr_clr");
    step(16'hFFF2, 1'b0, 16'h0000, 1'b1, 1'b1, "tmr_rd0");
    check("tmr_rd0.const", Mem_Data, 16'h0000);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b1, 1'b1, "tmr_rd1");
    check("tmr_rd1.const", Mem_Data, 16'h0001);
    step(16'hFFF2, 1'b1, 16'h0000, 1'b1, 1'b1, "tmr_clr2");
    for (int i = 0; i < 65535; i++) begin
      step(16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, "tmr_run");
    end
    step(16'hFFF2, 1'b0, 16'h0000, 1'b1, 1'b1, "tmr_max");
    check("tmr_max.const", Mem_Data, 16'hFFFF);
    step(16'hFFF2, 1'b0, 16'h0000, 1'b1, 1'b1, "tmr_wrap");
    check("tmr_wrap.const", Mem_Data, 16'h0000);

    // 5: unmapped access, status clear, reserved IO
    step(16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "unmapped_rd");
    check("unmapped_rd.const", Mem_Data, 16'h0000);
    check("unmapped_rd.berr", {15'b0, Bus_Error}, 16'h0001);
    step(16'hFFF3, 1'b0, 16'h0000, 1'b1, 1'b1, "status_rd");
    check("status_rd.const", Mem_Data, 16'h0001);
    step(16'hFFF3, 1'b1, 16'h0001, 1'b1, 1'b1, "status_clr");
    check("status_clr.berr", {15'b0, Bus_Error}, 16'h0000);
    step(16'hFFF8, 1'b0, 16'h0000, 1'b1, 1'b1, "reserved_rd");
    check("reserved_rd.const", Mem_Data, 16'h0000);
    check("reserved_rd.berr", {15'b0, Bus_Error}, 16'h0000);
    step(16'h0400, 1'b1, 16'hABCD, 1'b1, 1'b1, "unmapped_wr");
    check("unmapped_wr.echo", Mem_Data, 16'hABCD);
    check("unmapped_wr.berr", {15'b0, Bus_Error}, 16'h0001);

    // Random traffic over the whole map, including the region edges
    for (int i = 0; i < 600; i++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       a = 16'($urandom_range(0, 15));
        1:       a = 16'($urandom_range(1008, 1023));
        2, 3:    a = 16'hFFF0 + 16'($urandom_range(0, 15));
        4:       a = 16'($urandom_range(16'h0400, 16'hFFEF));
        default: a = ($urandom_range(0, 1) == 0) ? 16'h0400 : 16'hFFEF;
      endcase
      w = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      if ($urandom_range(0, 9) == 0) Switches = 8'($urandom);
      step(a, w, d, ($urandom_range(0, 99) != 0), 1'b1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
